// File: rtl/mcu_pkg.sv
// Shared register-file definitions for the control-processor pipeline.
package mcu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  function automatic logic [NUM_REGS-1:0] reg_bit(input reg_idx_t idx);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/mcu_scoreboard.sv
// Register scoreboard: tracks destinations of in-flight long-latency ops and
// holds decode on RAW/WAW hazards or when the outstanding-op budget is full.
module mcu_scoreboard
  import mcu_pkg::*;
#(
  parameter int MAX_PEND    = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rs1,
  input  logic [4:0]             issue_rs2,
  input  logic                   issue_uses_rs1,
  input  logic                   issue_uses_rs2,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_writes_rd,
  input  logic                   issue_long,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  output logic                   stall_decode,
  output logic [31:0]            pending_mask,
  output logic [3:0]             outstanding,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   sb_error
);
  localparam logic [3:0] MAX_PEND_C = 4'(MAX_PEND);

  logic [NUM_REGS-1:0]    r_pending;
  logic [3:0]             r_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_err;

  logic [NUM_REGS-1:0] w_wb_clr;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_raw1, w_raw2, w_waw, w_full;
  logic                w_stall, w_accept, w_inc, w_dec, w_err;
  logic [3:0]          w_cnt_eff;

  // Writeback in the same cycle is forwarded, so it no longer blocks consumers.
  assign w_wb_clr = wb_valid ? reg_bit(wb_rd) : '0;
  assign w_eff    = r_pending & ~w_wb_clr;

  assign w_raw1 = issue_uses_rs1  & (issue_rs1 != '0) & w_eff[issue_rs1];
  assign w_raw2 = issue_uses_rs2  & (issue_rs2 != '0) & w_eff[issue_rs2];
  assign w_waw  = issue_writes_rd & (issue_rd  != '0) & w_eff[issue_rd];

  // A spurious writeback at zero count never frees a slot.
  assign w_dec     = wb_valid & (r_cnt != '0);
  assign w_cnt_eff = r_cnt - {3'b000, w_dec};
  assign w_full    = issue_long & (w_cnt_eff == MAX_PEND_C);

  assign w_stall  = rst_n & issue_valid & (w_raw1 | w_raw2 | w_waw | w_full);
  assign w_accept = issue_valid & ~w_stall;
  assign w_inc    = w_accept & issue_long;

  assign w_set = (w_inc & issue_writes_rd & (issue_rd != '0)) ? reg_bit(issue_rd) : '0;
  assign w_pending_nxt = ((r_pending & ~w_wb_clr) | w_set) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};

  assign w_err = wb_valid & ((r_cnt == '0) | ((wb_rd != '0) & ~r_pending[wb_rd]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= r_cnt + {3'b000, w_inc} - {3'b000, w_dec};
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_err)
        r_err <= 1'b1;
    end
  end

  assign stall_decode = w_stall;
  assign pending_mask = r_pending;
  assign outstanding  = r_cnt;
  assign stall_cycles = r_stall_cnt;
  assign sb_error     = r_err;
endmodule

// File: tb/tb_mcu_scoreboard.sv
// Scoreboard-style bench: stimulus queues expected outputs per cycle, a
// negedge monitor pops and compares them against the DUT.
module tb_mcu_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_long;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        wb_valid;
  logic        stall_decode, sb_error;
  logic [31:0] pending_mask;
  logic [3:0]  outstanding;
  logic [15:0] stall_cycles;

  mcu_scoreboard #(.MAX_PEND(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd), .issue_long(issue_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_decode(stall_decode), .pending_mask(pending_mask), .outstanding(outstanding),
    .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] pm;
    logic [3:0]  outs;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_sc = '0;

  task automatic chk1(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk1(e.name, "stall", 32'(stall_decode), 32'(e.stall));
      chk1(e.name, "pending", pending_mask, e.pm);
      chk1(e.name, "outstanding", 32'(outstanding), 32'(e.outs));
      chk1(e.name, "sb_error", 32'(sb_error), 32'(e.err));
      chk1(e.name, "stall_cycles", 32'(stall_cycles), 32'(e.sc));
    end
  end

  task automatic idle();
    issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
    issue_long = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic iss(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic w, input logic lng);
    issue_valid = 1; issue_rs1 = rs1; issue_uses_rs1 = u1; issue_rs2 = rs2; issue_uses_rs2 = u2;
    issue_rd = rd; issue_writes_rd = w; issue_long = lng;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic st, input logic [31:0] pm,
                     input logic [3:0] outs, input logic err);
    exp_t e;
    e.name = nm; e.stall = st; e.pm = pm; e.outs = outs; e.err = err; e.sc = exp_sc;
    q.push_back(e);
    if (st && exp_sc != 16'hFFFF) exp_sc++;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    iss(5'd3, 1, 5'd4, 1, 5'd3, 1, 1);
    #2;
    cyc("reset", 0, 32'h0, 0, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Load-use through a long op, cleared by coincident writeback.
    iss(0, 0, 0, 0, 5'd5, 1, 1);   cyc("ld_x5", 0, 32'h0, 0, 0);
    iss(5'd5, 1, 0, 0, 0, 0, 0);   cyc("use_x5_stall", 1, 32'h20, 1, 0);
    iss(5'd5, 1, 0, 0, 0, 0, 0); wb(5'd5); cyc("use_x5_bypass", 0, 32'h20, 1, 0);
    cyc("x5_retired", 0, 32'h0, 0, 0);

    // Long op to x0 still occupies a slot.
    iss(0, 0, 0, 0, 5'd0, 1, 1);   cyc("long_x0", 0, 32'h0, 0, 0);
    iss(5'd0, 1, 0, 0, 0, 0, 0);   cyc("use_x0", 0, 32'h0, 1, 0);
    wb(5'd0);                      cyc("wb_x0", 0, 32'h0, 1, 0);
    cyc("x0_retired", 0, 32'h0, 0, 0);

    // Budget full at four outstanding.
    iss(0, 0, 0, 0, 5'd1, 1, 1);   cyc("fill1", 0, 32'h00, 0, 0);
    iss(0, 0, 0, 0, 5'd2, 1, 1);   cyc("fill2", 0, 32'h02, 1, 0);
    iss(0, 0, 0, 0, 5'd3, 1, 1);   cyc("fill3", 0, 32'h06, 2, 0);
    iss(0, 0, 0, 0, 5'd4, 1, 1);   cyc("fill4", 0, 32'h0E, 3, 0);
    iss(0, 0, 0, 0, 5'd6, 1, 1);   cyc("full_stall", 1, 32'h1E, 4, 0);
    iss(0, 0, 0, 0, 5'd6, 1, 1); wb(5'd1); cyc("full_wb_accept", 0, 32'h1E, 4, 0);
    wb(5'd2);                      cyc("drain2", 0, 32'h5C, 4, 0);
    wb(5'd3);                      cyc("drain3", 0, 32'h58, 3, 0);
    wb(5'd4);                      cyc("drain4", 0, 32'h50, 2, 0);
    wb(5'd6);                      cyc("drain6", 0, 32'h40, 1, 0);
    cyc("drained", 0, 32'h0, 0, 0);

    // WAW, then same-register wb+issue keeps the bit set.
    iss(0, 0, 0, 0, 5'd7, 1, 1);   cyc("ld_x7", 0, 32'h00, 0, 0);
    iss(0, 0, 0, 0, 5'd7, 1, 1);   cyc("waw_stall", 1, 32'h80, 1, 0);
    iss(0, 0, 0, 0, 5'd7, 1, 1); wb(5'd7); cyc("waw_wb_accept", 0, 32'h80, 1, 0);
    cyc("x7_still", 0, 32'h80, 1, 0);
    wb(5'd7);                      cyc("wb_x7", 0, 32'h80, 1, 0);
    cyc("x7_retired", 0, 32'h0, 0, 0);

    // RAW on rs2 only; unused rs1 matching a pending reg must not stall.
    iss(0, 0, 0, 0, 5'd10, 1, 1);  cyc("ld_x10", 0, 32'h0, 0, 0);
    iss(5'd10, 0, 0, 0, 0, 0, 0);  cyc("rs1_unused", 0, 32'h400, 1, 0);
    iss(0, 0, 5'd10, 1, 0, 0, 0);  cyc("raw2_stall", 1, 32'h400, 1, 0);
    wb(5'd10);                     cyc("wb_x10", 0, 32'h400, 1, 0);
    cyc("x10_retired", 0, 32'h0, 0, 0);

    // Spurious writeback: sticky error, count stays zero.
    wb(5'd9);                      cyc("spurious_wb", 0, 32'h0, 0, 0);
    cyc("err_set", 0, 32'h0, 0, 1);
    cyc("err_sticky", 0, 32'h0, 0, 1);

    // Saturating stall counter under a long RAW stall, then async reset.
    iss(0, 0, 0, 0, 5'd12, 1, 1);  cyc("ld_x12", 0, 32'h0, 0, 1);
    iss(5'd12, 1, 0, 0, 0, 0, 0);  cyc("long_stall_first", 1, 32'h1000, 1, 1);
    iss(5'd12, 1, 0, 0, 0, 0, 0);
    repeat (69998) begin
      if (exp_sc != 16'hFFFF) exp_sc++;
      @(posedge clk); #1;
    end
    cyc("stall_saturated", 1, 32'h1000, 1, 1);
    iss(5'd12, 1, 0, 0, 0, 0, 0);
    cyc("stall_still_sat", 1, 32'h1000, 1, 1);
    iss(5'd12, 1, 0, 0, 0, 0, 0);
    rst_n = 0;
    exp_sc = '0;
    cyc("reset_mid_stall", 0, 32'h0, 0, 0);
    rst_n = 1;
    wb(5'd9);                      cyc("wb_after_reset", 0, 32'h0, 0, 0);
    cyc("err_after_reset", 0, 32'h0, 0, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mcu_scoreboard.md
# mcu_scoreboard

Register scoreboard and issue scheduler for the control-processor pipeline. It tracks destination registers of issued long-latency operations (loads, multi-cycle mul/div) until their writeback returns, and holds decode on RAW/WAW dependences or a full outstanding-op budget. This generalises single-cycle load-use detection to variable-latency memory and arithmetic. It sits beside decode, fed by the decode stage and the writeback arbiter.

## Interface

Parameters:
- MAX_PEND, 4: maximum outstanding long-latency ops (1..15)
- STALL_CNT_W, 16: width of stall-cycle statistics counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode holds a valid instruction this cycle
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_uses_rs1  in  1  instruction reads rs1
- issue_uses_rs2  in  1  instruction reads rs2
- issue_rd  in  5  destination register
- issue_writes_rd  in  1  instruction writes rd
- issue_long  in  1  instruction is long-latency (load/mul/div)
- wb_valid  in  1  a long-latency result is written back this cycle
- wb_rd  in  5  destination of that result
- stall_decode  out  1  hold decode this cycle
- pending_mask  out  32  registered pending bits; bit 0 always 0
- outstanding  out  4  registered count of in-flight long ops
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles
- sb_error  out  1  sticky protocol error

## Operation

- Pending state: pending_q[31:1], cnt_q (0..MAX_PEND). Register x0 never pending.
- Effective pending: eff = pending_q with bit wb_rd cleared when wb_valid (writeback bypass; result forwarded in WB).
- stall_decode = issue_valid & (RAW1 | RAW2 | WAW | FULL):
  - RAW1: issue_uses_rs1 & rs1!=0 & eff[rs1]
  - RAW2: issue_uses_rs2 & rs2!=0 & eff[rs2]
  - WAW: issue_writes_rd & rd!=0 & eff[rd]
  - FULL: issue_long & (cnt_q - (wb_valid?1:0)) == MAX_PEND
- accept = issue_valid & ~stall_decode.
- Next pending: clear bit wb_rd if wb_valid; then set bit issue_rd if accept & issue_long & issue_writes_rd & rd!=0 (set wins on same register).
- Next count: cnt_q + (accept & issue_long) - wb_valid; simultaneous inc/dec -> unchanged. Long op with rd=0 or no rd write still counts and must be returned by one wb_valid.
- Errors (set sb_error, sticky until reset): wb_valid with cnt_q==0 (count stays 0); wb_valid with wb_rd!=0 and pending_q[wb_rd]==0. Pending bits and count otherwise update normally.
- stall_cycles increments every cycle stall_decode=1; saturates at all-ones.
- Pipeline flush is not an input: flushed-but-issued long ops still write back and are retired normally.

## Timing

- stall_decode combinational from inputs and registered state, same cycle; no added latency.
- Set/clear of pending bits and count visible on the cycle after the triggering edge.
- Minimum long-op dependence: issue at cycle N, wb at N+1 -> dependent consumer stalls only in cycle N+1 if present then, unstalled by bypass when wb_valid coincides.
- Reset (async assert, sync-to-clk release): pending_mask=0, outstanding=0, stall_cycles=0, sb_error=0; stall_decode=0 while rst_n low regardless of inputs.
- Reset mid-operation discards all pending state; writebacks after reset with no pending raise sb_error.

## Structure

- Shared package mcu_pkg: REG_ADDR_W=5, NUM_REGS=32, reg index typedef.
- Single module, no sub-modules; the saturating counters are inline.

## Test plan

- Load x5 accepted (issue_long, rd=5), next cycle consumer rs1=5 -> stall_decode=1, pending_mask=0x20, outstanding=1; wb_valid rd=5 same cycle as consumer -> stall_decode=0, then pending_mask=0, outstanding=0.
- Issue long rd=0, then rs1=0 consumer -> no stall; outstanding=1 until wb_valid rd=0 -> 0, sb_error=0.
- Four long ops rd=1..4 accepted, fifth long op rd=6 -> stall_decode=1 (FULL); wb_valid rd=1 same cycle -> accept, outstanding stays 4.
- Pending x7, new long op writing rd=7 -> WAW stall; wb_valid rd=7 and issue rd=7 same cycle -> accepted, pending_mask bit 7 remains 1.
- wb_valid rd=9 with nothing pending -> sb_error=1, outstanding stays 0; sb_error persists until rst_n low.
- Hold RAW stall for 70000 cycles with STALL_CNT_W=16 -> stall_cycles=0xFFFF; assert rst_n low mid-stall -> all outputs 0 immediately.
